barrier_sequencer: RTL and testbench
====================================

Name: barrier_sequencer

Overview:
- Game-flow controller directly upstream of the middle-lane barrier sprite: drives its `active` input and consumes its `in_position` and `o_sprite_hit` outputs.
- Spawns barriers after pseudo-random frame gaps and judges each pass against player-sprite overlap.
- Keeps score and lives, and declares game over.
- Runs on the pixel clock; advances on a one-cycle frame-tick strobe from the video timing block.

Parameters:
- GAP_MIN, 30: minimum frames between a barrier clearing and the next spawn.
- GAP_MASK, 6'h3F: mask applied to the LFSR to give the extra random gap frames.
- LIVES, 3: lives loaded at game start; range 1..15.
- SCORE_W, 16: score counter width.
- LFSR_SEED, 16'hACE1: LFSR reset value; a value of 0 is replaced by 16'h0001.
- RUN_TIMEOUT, 64: frames allowed in RUN before the barrier is abandoned.

Ports:
- i_clk  in  1  pixel clock.
- i_rst  in  1  synchronous, active-high reset.
- i_frame_tick  in  1  one-cycle pulse per frame, coincident with vsync start.
- i_start  in  1  level; starts or restarts the game from IDLE or GAME_OVER.
- i_barrier_pix  in  1  barrier opaque pixel at the current raster position (barrier o_sprite_hit).
- i_player_pix  in  1  player opaque pixel at the current raster position.
- i_in_position  in  1  barrier at its hit row (barrier in_position).
- o_active  out  1  to barrier `active`.
- o_hit_pulse  out  1  one cycle: player struck the barrier.
- o_pass_pulse  out  1  one cycle: barrier dodged.
- o_timeout_pulse  out  1  one cycle: RUN_TIMEOUT expired.
- o_score  out  SCORE_W  passes counted.
- o_lives  out  4  remaining lives.
- o_game_over  out  1  high in GAME_OVER.
- o_state  out  3  current state encoding, for debug.

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0; o_lives = 0.
  - LFSR = LFSR_SEED; gap and run counters 0; overlap latch 0.
- Reset mid-operation has the same effect on the next clock edge; o_active drops immediately so the barrier returns home.
- LFSR: 16-bit Galois, taps 16'hB400, advances on every i_frame_tick in all states except reset. It never reaches zero.
- Gap load value = GAP_MIN + (lfsr & GAP_MASK), sampled at the cycle of the load.
- All outputs are registered, with 1-cycle latency from the causing edge.
- State changes occur only on i_frame_tick, except:
  - IDLE/GAME_OVER exit on i_start.
  - RUN→CHECK on i_in_position.
- IDLE: o_active = 0. When i_start = 1:
  - lives ← LIVES, score ← 0, load gap counter, go to GAP.
- GAP: o_active = 0.
  - Each tick decrements the gap counter.
  - A tick that finds the counter at 0 moves to RUN and clears the run counter.
- RUN: o_active = 1; each tick increments the run counter.
  - i_in_position = 1 on any cycle → CHECK, with the overlap latch cleared that cycle.
  - Otherwise, a tick with run counter == RUN_TIMEOUT-1 → pulse o_timeout_pulse and go to CLEAR; lives and score unchanged.
  - If both occur on the same cycle, i_in_position wins.
- CHECK: o_active = 1.
  - Overlap latch sets on any cycle with i_barrier_pix & i_player_pix.
  - The next tick evaluates hit = latch | (same-cycle overlap), then goes to CLEAR.
  - On hit: o_hit_pulse; lives decrement, saturating at 0.
  - On no hit: o_pass_pulse; score increments, saturating at all-ones.
- CLEAR: o_active = 0 for exactly one frame.
  - The next tick goes to GAME_OVER if lives == 0; otherwise to GAP with the gap counter reloaded.
- GAME_OVER: o_active = 0, o_game_over = 1; score and lives hold.
  - i_start = 1 behaves as in IDLE.
- i_start is ignored in GAP, RUN, CHECK and CLEAR.
- o_hit_pulse, o_pass_pulse and o_timeout_pulse are mutually exclusive and never assert outside the evaluating edge.

Decomposition:
- Package barrier_pkg holds:
  - state enum (IDLE=0, GAP=1, RUN=2, CHECK=3, CLEAR=4, GAME_OVER=5), 3-bit;
  - LFSR width 16 and tap constant 16'hB400;
  - lives width 4.
- One sub-module, frame_lfsr (16-bit Galois, seed parameter, step enable). The FSM, counters and scoring stay in barrier_sequencer.

Test Plan:
- Reset, then i_start for 1 cycle → o_lives = 3, o_score = 0, state GAP; o_active rises after GAP_MIN + (LFSR_SEED & 6'h3F) + 1 ticks, exactly 1 cycle after that tick.
- In RUN, assert i_in_position, no pixel overlap, then tick → o_pass_pulse for 1 cycle, o_score = 1; o_active low for exactly one frame, then GAP.
- In CHECK, one cycle with i_barrier_pix = i_player_pix = 1 mid-frame → at next tick o_hit_pulse, o_lives 3→2, score unchanged.
- Overlap only on the same cycle as the evaluating tick → counted as a hit.
- Three hits → GAME_OVER with o_game_over = 1 and o_active = 0; i_start → lives = 3, score = 0, GAP.
- RUN with i_in_position held low for 64 ticks → o_timeout_pulse on the 64th tick, lives and score unchanged.
- i_rst asserted during CHECK → o_active = 0 next cycle, all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/barrier_pkg.sv
// Shared types and constants for the barrier game-flow controller.
//   state_t   : sequencer state encoding (also exported on o_state for debug)
//   LFSR_W    : width of the frame-gap LFSR
//   LFSR_TAPS : Galois feedback mask for the right-shifting LFSR
//   LIVES_W   : width of the lives counter
package barrier_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GAP       = 3'd1,
    RUN       = 3'd2,
    CHECK     = 3'd3,
    CLEAR     = 3'd4,
    GAME_OVER = 3'd5
  } state_t;

  localparam int unsigned     LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam int unsigned     LIVES_W   = 4;

endpackage

// File: rtl/barrier_sequencer_frame_lfsr.sv
// 16-bit right-shifting Galois LFSR used to randomise inter-barrier gaps.
//   clk   : pixel clock
//   rst   : synchronous active-high reset, loads SEED (zero seed forced to 1)
//   step  : advance one position this cycle
//   value : current LFSR contents
module frame_lfsr
  import barrier_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  output logic [LFSR_W-1:0] value
);

  // An all-zero state would lock the LFSR, so a zero seed is replaced.
  localparam logic [LFSR_W-1:0] SEED_NZ = (SEED == '0) ? LFSR_W'(1) : SEED;

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= SEED_NZ;
    end else if (step) begin
      value <= {1'b0, value[LFSR_W-1:1]} ^ (value[0] ? LFSR_TAPS : '0);
    end
  end

endmodule

// File: rtl/barrier_sequencer.sv
// Game-flow controller for the middle-lane barrier sprite. Spawns a barrier
// after a pseudo-random number of frames, judges each pass against player
// overlap, and keeps score, lives and game-over status.
//   i_clk, i_rst      : pixel clock, synchronous active-high reset
//   i_frame_tick      : one-cycle strobe per frame
//   i_start           : starts/restarts the game from IDLE or GAME_OVER
//   i_barrier_pix     : barrier opaque pixel at the current raster position
//   i_player_pix      : player opaque pixel at the current raster position
//   i_in_position     : barrier has reached its hit row
//   o_active          : drives the barrier sprite's active input
//   o_hit_pulse       : one cycle, barrier struck the player
//   o_pass_pulse      : one cycle, barrier dodged
//   o_timeout_pulse   : one cycle, barrier never reached its hit row
//   o_score, o_lives  : passes counted, lives remaining
//   o_game_over       : high while in GAME_OVER
//   o_state           : current state encoding
module barrier_sequencer
  import barrier_pkg::*;
#(
  parameter int unsigned       GAP_MIN     = 30,
  parameter logic [5:0]        GAP_MASK    = 6'h3F,
  parameter int unsigned       LIVES       = 3,
  parameter int unsigned       SCORE_W     = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 16'hACE1,
  parameter int unsigned       RUN_TIMEOUT = 64
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_frame_tick,
  input  logic               i_start,
  input  logic               i_barrier_pix,
  input  logic               i_player_pix,
  input  logic               i_in_position,
  output logic               o_active,
  output logic               o_hit_pulse,
  output logic               o_pass_pulse,
  output logic               o_timeout_pulse,
  output logic [SCORE_W-1:0] o_score,
  output logic [LIVES_W-1:0] o_lives,
  output logic               o_game_over,
  output logic [2:0]         o_state
);

  localparam int unsigned          RUN_CNT_W = $clog2(RUN_TIMEOUT + 1);
  localparam logic [RUN_CNT_W-1:0] RUN_LAST  = RUN_CNT_W'(RUN_TIMEOUT - 1);

  state_t               state;
  logic [LFSR_W-1:0]    lfsr;
  logic [LFSR_W-1:0]    gap_cnt;
  logic [LFSR_W-1:0]    gap_load;
  logic [RUN_CNT_W-1:0] run_cnt;
  logic                 overlap;
  logic                 pix_overlap;

  frame_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (i_clk),
    .rst   (i_rst),
    .step  (i_frame_tick),
    .value (lfsr)
  );

  assign gap_load    = LFSR_W'(GAP_MIN) + (lfsr & LFSR_W'(GAP_MASK));
  assign pix_overlap = i_barrier_pix & i_player_pix;
  assign o_state     = state;

  // Outputs are assigned alongside each state transition so they line up
  // with the new state on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= IDLE;
      o_active        <= 1'b0;
      o_hit_pulse     <= 1'b0;
      o_pass_pulse    <= 1'b0;
      o_timeout_pulse <= 1'b0;
      o_score         <= '0;
      o_lives         <= '0;
      o_game_over     <= 1'b0;
      gap_cnt         <= '0;
      run_cnt         <= '0;
      overlap         <= 1'b0;
    end else begin
      o_hit_pulse     <= 1'b0;
      o_pass_pulse    <= 1'b0;
      o_timeout_pulse <= 1'b0;

      case (state)
        IDLE, GAME_OVER: begin
          if (i_start) begin
            o_lives     <= LIVES_W'(LIVES);
            o_score     <= '0;
            gap_cnt     <= gap_load;
            o_game_over <= 1'b0;
            o_active    <= 1'b0;
            state       <= GAP;
          end
        end

        GAP: begin
          if (i_frame_tick) begin
            if (gap_cnt == '0) begin
              run_cnt  <= '0;
              o_active <= 1'b1;
              state    <= RUN;
            end else begin
              gap_cnt <= gap_cnt - LFSR_W'(1);
            end
          end
        end

        RUN: begin
          // Reaching the hit row takes priority over a coincident timeout.
          if (i_in_position) begin
            overlap <= 1'b0;
            state   <= CHECK;
          end else if (i_frame_tick) begin
            if (run_cnt == RUN_LAST) begin
              o_timeout_pulse <= 1'b1;
              o_active        <= 1'b0;
              state           <= CLEAR;
            end else begin
              run_cnt <= run_cnt + RUN_CNT_W'(1);
            end
          end
        end

        CHECK: begin
          if (i_frame_tick) begin
            if (overlap | pix_overlap) begin
              o_hit_pulse <= 1'b1;
              if (o_lives != '0) o_lives <= o_lives - LIVES_W'(1);
            end else begin
              o_pass_pulse <= 1'b1;
              if (o_score != '1) o_score <= o_score + SCORE_W'(1);
            end
            o_active <= 1'b0;
            state    <= CLEAR;
          end else if (pix_overlap) begin
            overlap <= 1'b1;
          end
        end

        CLEAR: begin
          if (i_frame_tick) begin
            if (o_lives == '0) begin
              o_game_over <= 1'b1;
              state       <= GAME_OVER;
            end else begin
              gap_cnt <= gap_load;
              state   <= GAP;
            end
          end
        end

        default: begin
          o_active    <= 1'b0;
          o_game_over <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_barrier_sequencer.sv
module tb_barrier_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        bpix = 1'b0;
  logic        ppix = 1'b0;
  logic        inpos = 1'b0;
  logic        active;
  logic        hit_p;
  logic        pass_p;
  logic        tmo_p;
  logic [15:0] score;
  logic [3:0]  lives;
  logic        game_over;
  logic [2:0]  state;

  int total = 0;
  int bad = 0;
  logic [15:0] lfsr_m = 16'hACE1;
  int gap_exp = 0;

  barrier_sequencer #(
    .GAP_MIN     (30),
    .GAP_MASK    (6'h3F),
    .LIVES       (3),
    .SCORE_W     (16),
    .LFSR_SEED   (16'hACE1),
    .RUN_TIMEOUT (64)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_frame_tick    (tick),
    .i_start         (start),
    .i_barrier_pix   (bpix),
    .i_player_pix    (ppix),
    .i_in_position   (inpos),
    .o_active        (active),
    .o_hit_pulse     (hit_p),
    .o_pass_pulse    (pass_p),
    .o_timeout_pulse (tmo_p),
    .o_score         (score),
    .o_lives         (lives),
    .o_game_over     (game_over),
    .o_state         (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One frame strobe; the reference LFSR advances with it.
  task automatic frame();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    lfsr_m = {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
  endtask

  function automatic int gap_of(input logic [15:0] m);
    return 30 + int'(m & 16'h003F);
  endfunction

  task automatic wait_run(input int exp_ticks);
    int n;
    n = 0;
    while (n < 200 && !active) begin
      frame();
      n++;
    end
    chk("gap_ticks", n, exp_ticks);
    chk("run_state", {29'd0, state}, 32'd2);
  endtask

  task automatic enter_check();
    inpos = 1'b1;
    cyc(1);
    inpos = 1'b0;
    chk("check_state", {29'd0, state}, 32'd3);
    chk("check_active", {31'd0, active}, 32'd1);
  endtask

  task automatic clear_to_gap();
    gap_exp = gap_of(lfsr_m);
    frame();
    chk("clear_to_gap", {29'd0, state}, 32'd1);
  endtask

  initial begin
    // Reset values
    cyc(3);
    rst = 1'b0;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_active", {31'd0, active}, 32'd0);
    chk("rst_lives", {28'd0, lives}, 32'd0);
    chk("rst_score", {16'd0, score}, 32'd0);
    chk("rst_go", {31'd0, game_over}, 32'd0);
    chk("rst_pulses", {29'd0, hit_p, pass_p, tmo_p}, 32'd0);

    // Start: gap = 30 + (0xACE1 & 0x3F) = 63, so RUN on the 64th tick
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("start_lives", {28'd0, lives}, 32'd3);
    chk("start_score", {16'd0, score}, 32'd0);
    chk("start_state", {29'd0, state}, 32'd1);
    wait_run(64);

    // Pass: no overlap while in CHECK
    enter_check();
    cyc(3);
    frame();
    chk("pass_pulse", {31'd0, pass_p}, 32'd1);
    chk("pass_hit", {31'd0, hit_p}, 32'd0);
    chk("pass_score", {16'd0, score}, 32'd1);
    chk("pass_state", {29'd0, state}, 32'd4);
    chk("pass_active", {31'd0, active}, 32'd0);
    cyc(1);
    chk("pass_pulse_1cyc", {31'd0, pass_p}, 32'd0);
    clear_to_gap();
    chk("gap_active", {31'd0, active}, 32'd0);

    // Hit from a mid-frame overlap
    wait_run(gap_exp + 1);
    enter_check();
    cyc(2);
    bpix = 1'b1; ppix = 1'b1;
    cyc(1);
    bpix = 1'b0; ppix = 1'b0;
    cyc(2);
    frame();
    chk("hit1_pulse", {31'd0, hit_p}, 32'd1);
    chk("hit1_pass", {31'd0, pass_p}, 32'd0);
    chk("hit1_lives", {28'd0, lives}, 32'd2);
    chk("hit1_score", {16'd0, score}, 32'd1);
    clear_to_gap();

    // Hit from overlap only on the evaluating tick cycle
    wait_run(gap_exp + 1);
    enter_check();
    cyc(3);
    bpix = 1'b1; ppix = 1'b1;
    frame();
    bpix = 1'b0; ppix = 1'b0;
    chk("hit2_pulse", {31'd0, hit_p}, 32'd1);
    chk("hit2_lives", {28'd0, lives}, 32'd1);
    clear_to_gap();

    // Third hit leads to GAME_OVER
    wait_run(gap_exp + 1);
    enter_check();
    bpix = 1'b1; ppix = 1'b1;
    cyc(1);
    bpix = 1'b0; ppix = 1'b0;
    frame();
    chk("hit3_pulse", {31'd0, hit_p}, 32'd1);
    chk("hit3_lives", {28'd0, lives}, 32'd0);
    frame();
    chk("go_state", {29'd0, state}, 32'd5);
    chk("go_flag", {31'd0, game_over}, 32'd1);
    chk("go_active", {31'd0, active}, 32'd0);
    chk("go_score", {16'd0, score}, 32'd1);
    frame();
    frame();
    chk("go_hold_state", {29'd0, state}, 32'd5);
    chk("go_hold_lives", {28'd0, lives}, 32'd0);

    // Restart from GAME_OVER
    gap_exp = gap_of(lfsr_m);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("restart_lives", {28'd0, lives}, 32'd3);
    chk("restart_score", {16'd0, score}, 32'd0);
    chk("restart_state", {29'd0, state}, 32'd1);
    chk("restart_go", {31'd0, game_over}, 32'd0);

    // Pass after a hit: overlap latch must start cleared
    wait_run(gap_exp + 1);
    enter_check();
    cyc(2);
    frame();
    chk("pass2_pulse", {31'd0, pass_p}, 32'd1);
    chk("pass2_score", {16'd0, score}, 32'd1);
    clear_to_gap();

    // i_start ignored in GAP
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("ign_start_state", {29'd0, state}, 32'd1);
    chk("ign_start_score", {16'd0, score}, 32'd1);

    // Timeout after 64 ticks in RUN
    wait_run(gap_exp + 1);
    repeat (63) frame();
    chk("pre_tmo_state", {29'd0, state}, 32'd2);
    chk("pre_tmo_pulse", {31'd0, tmo_p}, 32'd0);
    frame();
    chk("tmo_pulse", {31'd0, tmo_p}, 32'd1);
    chk("tmo_state", {29'd0, state}, 32'd4);
    chk("tmo_active", {31'd0, active}, 32'd0);
    chk("tmo_lives", {28'd0, lives}, 32'd3);
    chk("tmo_score", {16'd0, score}, 32'd1);
    chk("tmo_no_hit", {30'd0, hit_p, pass_p}, 32'd0);
    cyc(1);
    chk("tmo_pulse_1cyc", {31'd0, tmo_p}, 32'd0);

    // Reset during CHECK
    clear_to_gap();
    wait_run(gap_exp + 1);
    enter_check();
    rst = 1'b1;
    cyc(1);
    chk("mid_rst_active", {31'd0, active}, 32'd0);
    chk("mid_rst_state", {29'd0, state}, 32'd0);
    chk("mid_rst_lives", {28'd0, lives}, 32'd0);
    chk("mid_rst_score", {16'd0, score}, 32'd0);
    chk("mid_rst_go", {31'd0, game_over}, 32'd0);
    rst = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
